// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and queues {pc, inst} pairs for decode. Optional counters under FETCH_PERF_CNT_EN.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic [31:0] id_pc
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t [DEPTH-1:0] fifo;
    logic [31:0]        fetch_pc, issued_pc;
    logic               outstanding, discard;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               resp, push, pop, grant, drop;
    logic               unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign resp     = imem_rvalid && outstanding;
    assign push     = resp && !discard && !redirect;
    assign drop     = resp && (discard || redirect);
    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready && !redirect;

    // Holding the request until the FIFO has a free slot reserves room for the reply.
    assign imem_req  = !reset && !outstanding && !redirect && (count < CW'(DEPTH));
    assign grant     = imem_req && imem_gnt;
    assign imem_addr = fetch_pc;

    assign id_inst = id_valid ? fifo[rd_ptr].inst : NOP;
    assign id_pc   = id_valid ? fifo[rd_ptr].pc   : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            issued_pc   <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            // A reply landing this cycle is swallowed here; otherwise mark it stale.
            if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end else if (outstanding) begin
                discard <= 1'b1;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (resp) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end else if (grant) begin
                outstanding <= 1'b1;
                issued_pc   <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {issued_pc, imem_rdata};
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            perf_flushed <= perf_flushed + (redirect ? 32'(count) : 32'd0) + {31'd0, drop};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory responder plus a
// queue of expected {pc, inst} entries checked against the decode-side outputs.
module tb_fetch_queue;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_inst, id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
        .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    int          checks = 0, failures = 0;
    bit          pend = 0, stale = 0;
    int          wt = 0, lat = 1;
    logic [31:0] paddr = '0, exp_pc = RESET_PC;
    int          exp_fetched = 0, exp_flushed = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive responder at negedge, check and advance the model, cross posedge.
    task automatic tick();
        bit exp_req;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            wt--;
            if (wt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(paddr);
            end
        end
        #1;
        exp_req = !pend && !redirect && (q.size() < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", imem_addr, exp_pc);
        chk("id_valid", 32'(id_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_inst", id_inst, q[0].inst);
        end else begin
            chk("id_pc_idle", id_pc, 32'h0);
            chk("id_inst_idle", id_inst, NOP);
        end
        if (q.size() != 0 && id_ready && !redirect) void'(q.pop_front());
        if (redirect) begin
            exp_flushed += q.size();
            q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
            if (pend && !imem_rvalid) stale = 1;
        end
        if (imem_rvalid) begin
            if (stale || redirect) exp_flushed++;
            else begin
                q.push_back('{paddr, memf(paddr)});
                exp_fetched++;
            end
            pend  = 0;
            stale = 0;
        end else if (exp_req && imem_gnt) begin
            pend   = 1;
            wt     = lat;
            paddr  = exp_pc;
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        reset = 1'b0;

        // Backpressure: exactly DEPTH entries captured, request drops
        for (int i = 0; i < 8; i++) tick();
        chk("bp_imem_req", 32'(imem_req), 32'h0);
        chk("bp_id_valid", 32'(id_valid), 32'h1);
        chk("bp_head_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        lat      = 3;
        tick();
        chk("bp_second_pc", id_pc, 32'h4);
        chk("bp_resume_addr", imem_addr, 32'h8);

        // Redirect while 0x8 in flight (latency 3 -> discard path)
        for (int i = 0; i < 20 && !(pend && paddr == 32'h8); i++) tick();
        chk("inflight_8", 32'(pend && paddr == 32'h8), 32'h1);
        do_redirect(32'h100);
        chk("redir_addr_100", imem_addr, 32'h100);
        lat = 1;
        for (int i = 0; i < 20 && !id_valid; i++) tick();
        chk("redir_first_pc", id_pc, 32'h100);

        // Stall the grant: request and address must hold
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        imem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Unaligned redirect target, then redirect coinciding with rvalid
        do_redirect(32'h203);
        chk("redir_align", imem_addr, 32'h200);
        for (int i = 0; i < 20 && !(pend && !stale && wt == 1); i++) tick();
        chk("rvalid_next", 32'(pend && !stale && wt == 1), 32'h1);
        do_redirect(32'h300);
        for (int i = 0; i < 20 && !id_valid; i++) tick();
        chk("same_cycle_drop_pc", id_pc, 32'h300);

        // PC wrap
        do_redirect(32'hFFFF_FFFE);
        for (int i = 0; i < 20 && !id_valid; i++) tick();
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", id_inst, memf(32'hFFFF_FFFC));
        chk("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) tick();

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'(exp_fetched));
        chk("perf_flushed", perf_flushed, 32'(exp_flushed));
`endif

        // Reset mid-transaction with one entry queued and one read in flight
        lat      = 4;
        id_ready = 1'b0;
        for (int i = 0; i < 30 && !(q.size() == 1 && pend); i++) tick();
        chk("pre_rst_state", 32'(q.size() == 1 && pend), 32'h1);
        #1 reset = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
        chk("mid_rst_id_inst", id_inst, NOP);
        chk("mid_rst_imem_req", 32'(imem_req), 32'h0);
        chk("mid_rst_id_pc", id_pc, 32'h0);
        q.delete();
        pend        = 0;
        stale       = 0;
        exp_pc      = RESET_PC;
        exp_fetched = 0;
        exp_flushed = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("post_rst_perf_fetched", perf_fetched, 32'h0);
        chk("post_rst_perf_flushed", perf_flushed, 32'h0);
`endif
        lat      = 1;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
